fir_filter_pipe_chain: RTL and testbench
========================================

Name: fir_filter_pipe_chain

Overview:
- Parametrised multi-stage elastic pipeline register for the FIR datapath.
- Carries accumulator value plus channel tag through DEPTH stages with per-stage valid/ready backpressure and bubble collapse.
- Keeps global freeze and flush controls.
- Sits between the MAC/accumulate stage and the output formatter.
- Replaces single-stage fixed-width accumulator registers.

Parameters:
- DATA_WIDTH, 32, accumulator/data width in bits.
- DEPTH, 3, number of register stages; legal range 1..16.
- CHANNELS, 4, number of interleaved filter channels; tag width CH_W = max(1, $clog2(CHANNELS)).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- freeze  in  1  global stall; holds every stage.
- flush  in  1  synchronous clear of all stage valids.
- in_valid  in  1  upstream word valid.
- in_data  in  DATA_WIDTH  upstream accumulator value.
- in_chan  in  CH_W  upstream channel tag.
- in_ready  out  1  chain accepts in_* this cycle.
- out_valid  out  1  output word valid.
- out_data  out  DATA_WIDTH  output accumulator value.
- out_chan  out  CH_W  output channel tag.
- out_ready  in  1  downstream accepts output this cycle.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages (registered).

Behaviour:
- Reset (rst low, async): all stage valid, data, chan = 0; occupancy = 0. Outputs in_ready and out_valid follow from these reset values.
- Stage i holds valid_q[i], data_q[i], chan_q[i]. Stage 0 is fed by in_*; stage DEPTH-1 drives out_*.
- take[DEPTH-1] = out_ready & ~freeze & ~flush; take[i] = en[i+1] for i < DEPTH-1.
- en[i] = ~freeze & ~flush & (~valid_q[i] | take[i]). A stage loads whenever it is empty or being drained (bubble collapse).
- in_ready = en[0]. This is combinational from out_ready through the chain, with a path of length DEPTH; that is accepted.
- out_valid = valid_q[DEPTH-1] & ~freeze & ~flush. out_data and out_chan = stage DEPTH-1 registers, always driven.
- On en[i]:
  - valid_q[i] <= incoming valid (in_valid for stage 0, valid_q[i-1] otherwise).
  - data_q and chan_q load only when the incoming valid is 1; otherwise they hold.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - Words are never dropped, duplicated or reordered.
- Latency: accepted word appears on out_valid exactly DEPTH cycles later when the chain is unstalled.
- Throughput: 1 word/cycle with out_ready held high.
- freeze=1: all registers hold; in_ready=0; out_valid=0; occupancy holds.
- flush=1 (priority over freeze and in_valid):
  - Next edge clears all valid_q and sets occupancy = 0.
  - data/chan registers hold.
  - In the flush cycle, in_ready=0 and out_valid=0, so no transfer occurs.
- Occupancy update each edge:
  - +1 on input transfer only.
  - -1 on output transfer only.
  - Unchanged on both or neither.
  - 0 on flush.
- Invariant: occupancy == popcount(valid_q) at every cycle.
- Full chain with out_ready=0: in_ready=0. Simultaneous out_ready=1 and in_valid=1 on a full chain: shift through, occupancy unchanged.
- DEPTH=1: take[0] = out_ready & ~freeze & ~flush; single skidless register.
- Reset asserted mid-stream: immediate clear regardless of clk. First accept is allowed on the first edge after release.

Decomposition:
- fir_filter_pkg holds:
  - FIR_ACC_WIDTH = 32 and FIR_MAX_DEPTH = 16 constants.
  - chan_w(CHANNELS) function.
  - fir_word_t struct typedef {data, chan}, parametrised by width through a localparam-sized variant in the chain.
- One sub-module: fir_filter_pipe_stage, which holds one valid/data/chan register with en input and async active-low reset. It is instantiated DEPTH times by generate.
- Chain-level logic: en/take computation and occupancy counter.

Test Plan:
- Streaming: DEPTH=3; reset, then in_valid=1 with data 0x10,0x11,0x12,0x13 on consecutive cycles, out_ready=1 -> out_valid first at cycle 3 after the first accept, data 0x10..0x13 in order, occupancy ramps 1,2,3 and holds 3.
- Backpressure/fill: out_ready=0, push 5 words -> in_ready drops after 3 accepts, occupancy=3. Raise out_ready -> 0x10 emitted first, one word per cycle, no loss.
- Bubble collapse: send 0xA0, idle 2 cycles, send 0xA1 with out_ready=0 -> both collapse into stages 2 and 1, occupancy=2; release gives 0xA0 then 0xA1 on back-to-back cycles.
- Freeze: mid-stream freeze for 4 cycles -> in_ready=0, out_valid=0, registers and occupancy unchanged. Stream resumes with identical sequence and channel tags (chan 0,1,2,3 rotating).
- Flush: occupancy=3 with freeze=1 and flush=1 simultaneously -> next cycle occupancy=0, out_valid=0. Subsequent word 0x55 emerges after exactly DEPTH cycles.
- Async reset: assert rst low between clock edges with occupancy=2 -> valids, occupancy and out_valid clear immediately. Repeat streaming test with DEPTH=1 -> latency 1, full rate.

Source files
------------

// File: rtl/fir_filter_pkg.sv
// Shared constants, types and helpers for the FIR output pipeline chain.
package fir_filter_pkg;

   localparam int FIR_ACC_WIDTH = 32;
   localparam int FIR_MAX_DEPTH = 16;
   localparam int FIR_MAX_CH_W  = 4;

   function automatic int chan_w(input int channels);
      return (channels > 2) ? $clog2(channels) : 1;
   endfunction

   typedef struct packed {
      logic [FIR_ACC_WIDTH-1:0] data;
      logic [FIR_MAX_CH_W-1:0]  chan;
   } fir_word_t;

endpackage

// File: rtl/fir_filter_pipe_stage.sv
// One elastic register slot: valid bit plus payload word.
module fir_filter_pipe_stage
   import fir_filter_pkg::*;
#(
   parameter type word_t = fir_word_t
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  logic  clr,
   input  logic  prev_valid,
   input  word_t prev_word,
   output logic  valid,
   output word_t word
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         word  <= '0;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (en) begin
         valid <= prev_valid;
         // payload only moves with a real word so bubbles keep old data
         if (prev_valid) word <= prev_word;
      end
   end

endmodule

// File: rtl/fir_filter_pipe_chain.sv
// DEPTH-stage elastic pipeline between the MAC stage and output formatter,
// with bubble collapse, global freeze/flush and a registered occupancy count.
module fir_filter_pipe_chain
   import fir_filter_pkg::*;
#(
   parameter  int DATA_WIDTH = FIR_ACC_WIDTH,
   parameter  int DEPTH      = 3,
   parameter  int CHANNELS   = 4,
   localparam int CH_W       = chan_w(CHANNELS),
   localparam int OCC_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CH_W-1:0]       in_chan,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CH_W-1:0]       out_chan,
   input  logic                  out_ready,
   output logic [OCC_W-1:0]      occupancy
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [CH_W-1:0]       chan;
   } word_t;

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] prev_valid;
   logic [DEPTH-1:0] en;
   word_t            word_q    [DEPTH];
   word_t            prev_word [DEPTH];
   logic             go;
   logic             carry;
   logic             in_xfer;
   logic             out_xfer;

   assign go = ~freeze & ~flush;

   // walk from the output end so each stage sees whether its successor drains
   always_comb begin
      en    = '0;
      carry = go & out_ready;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         en[i] = go & (~valid_q[i] | carry);
         carry = en[i];
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      if (g == 0) begin : g_head
         assign prev_valid[g] = in_valid;
         assign prev_word[g]  = {in_data, in_chan};
      end else begin : g_body
         assign prev_valid[g] = valid_q[g-1];
         assign prev_word[g]  = word_q[g-1];
      end

      fir_filter_pipe_stage #(
         .word_t(word_t)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .en        (en[g]),
         .clr       (flush),
         .prev_valid(prev_valid[g]),
         .prev_word (prev_word[g]),
         .valid     (valid_q[g]),
         .word      (word_q[g])
      );
   end

   assign in_ready  = en[0];
   assign out_valid = valid_q[DEPTH-1] & go;
   assign out_data  = word_q[DEPTH-1].data;
   assign out_chan  = word_q[DEPTH-1].chan;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else if (in_xfer & ~out_xfer) begin
         occupancy <= occupancy + OCC_W'(1);
      end else if (out_xfer & ~in_xfer) begin
         occupancy <= occupancy - OCC_W'(1);
      end
   end

endmodule

// File: tb/tb_fir_filter_pipe_chain.sv
// Bench for the FIR pipe chain: DEPTH=3 and DEPTH=1 instances share stimulus
// and are checked against a word-position queue model plus directed vectors.
module tb_fir_filter_pipe_chain;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze, flush, in_valid, out_ready;
   logic [31:0] in_data;
   logic [1:0]  in_chan;

   logic        ird3, ov3, ird1, ov1;
   logic [31:0] od3, od1;
   logic [1:0]  oc3, oc1;
   logic [1:0]  occ3;
   logic [0:0]  occ1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fir_filter_pipe_chain #(.DATA_WIDTH(32), .DEPTH(3), .CHANNELS(4)) u_d3 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_chan(in_chan),
      .in_ready(ird3), .out_valid(ov3), .out_data(od3), .out_chan(oc3),
      .out_ready(out_ready), .occupancy(occ3)
   );

   fir_filter_pipe_chain #(.DATA_WIDTH(32), .DEPTH(1), .CHANNELS(4)) u_d1 (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_chan(in_chan),
      .in_ready(ird1), .out_valid(ov1), .out_data(od1), .out_chan(oc1),
      .out_ready(out_ready), .occupancy(occ1)
   );

   // model: ordered list of words, each tagged with its slot position
   typedef struct {
      logic [31:0] data;
      logic [1:0]  chan;
      int          pos;
   } mw_t;
   typedef mw_t mq_t[$];

   mq_t q3, q1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // every word steps forward when the slot ahead is free after older words move
   task automatic m_move(input mq_t qi, input int depth, input bit ordy,
                         output mq_t qo);
      int lim;
      mw_t w;
      qo  = {};
      lim = depth;
      for (int i = 0; i < qi.size(); i++) begin
         w = qi[i];
         if (w.pos + 1 < lim) begin
            w.pos = w.pos + 1;
         end else if (i == 0 && w.pos == depth - 1 && ordy) begin
            continue;
         end
         qo.push_back(w);
         lim = w.pos;
      end
   endtask

   task automatic m_pred(input mq_t q, input int depth, input bit fz,
                         input bit fl, input bit ordy, output bit ird,
                         output bit ov, output logic [31:0] od,
                         output logic [1:0] oc);
      mq_t mv;
      bit  go;
      go = !fz && !fl;
      m_move(q, depth, ordy, mv);
      ird = go && (mv.size() == 0 || mv[mv.size()-1].pos > 0);
      ov  = go && q.size() > 0 && q[0].pos == depth - 1;
      od  = ov ? q[0].data : 32'h0;
      oc  = ov ? q[0].chan : 2'h0;
   endtask

   task automatic m_step(input mq_t qi, input int depth, input bit fz,
                         input bit fl, input bit iv, input logic [31:0] id,
                         input logic [1:0] ic, input bit ordy,
                         output mq_t qo);
      mw_t w;
      if (fl) begin
         qo = {};
      end else if (fz) begin
         qo = qi;
      end else begin
         m_move(qi, depth, ordy, qo);
         if (iv && (qo.size() == 0 || qo[qo.size()-1].pos > 0)) begin
            w.data = id;
            w.chan = ic;
            w.pos  = 0;
            qo.push_back(w);
         end
      end
   endtask

   logic        s_ird3, s_ov3, s_ird1, s_ov1;
   logic [31:0] s_od3, s_od1;
   int          s_occ3, s_occ1;

   task automatic step(input bit fz, input bit fl, input bit iv,
                       input logic [31:0] id, input logic [1:0] ic,
                       input bit ordy);
      bit          e_ird, e_ov;
      logic [31:0] e_od;
      logic [1:0]  e_oc;
      freeze    = fz;
      flush     = fl;
      in_valid  = iv;
      in_data   = id;
      in_chan   = ic;
      out_ready = ordy;
      #1;
      s_ird3 = ird3; s_ov3 = ov3; s_od3 = od3; s_occ3 = int'(occ3);
      s_ird1 = ird1; s_ov1 = ov1; s_od1 = od1; s_occ1 = int'(occ1);
      m_pred(q3, 3, fz, fl, ordy, e_ird, e_ov, e_od, e_oc);
      chk("d3_in_ready", 32'(ird3), 32'(e_ird));
      chk("d3_out_valid", 32'(ov3), 32'(e_ov));
      chk("d3_occupancy", 32'(occ3), 32'(q3.size()));
      if (e_ov) begin
         chk("d3_out_data", od3, e_od);
         chk("d3_out_chan", 32'(oc3), 32'(e_oc));
      end
      m_pred(q1, 1, fz, fl, ordy, e_ird, e_ov, e_od, e_oc);
      chk("d1_in_ready", 32'(ird1), 32'(e_ird));
      chk("d1_out_valid", 32'(ov1), 32'(e_ov));
      chk("d1_occupancy", 32'(occ1), 32'(q1.size()));
      if (e_ov) begin
         chk("d1_out_data", od1, e_od);
         chk("d1_out_chan", 32'(oc1), 32'(e_oc));
      end
      @(posedge clk);
      m_step(q3, 3, fz, fl, iv, id, ic, ordy, q3);
      m_step(q1, 1, fz, fl, iv, id, ic, ordy, q1);
      @(negedge clk);
   endtask

   typedef struct {
      bit          fz, fl, iv;
      logic [31:0] id;
      bit          ordy;
      bit          e_ird, e_ov;
      logic [31:0] e_od;
      int          e_occ;
   } vec_t;

   vec_t tbl[8];
   int   acc;
   int   lat;
   bit   hit;

   initial begin
      // streaming DEPTH=3: first output three cycles after first accept
      tbl[0] = '{0, 0, 1, 32'h10, 1, 1, 0, 32'h0,  0};
      tbl[1] = '{0, 0, 1, 32'h11, 1, 1, 0, 32'h0,  1};
      tbl[2] = '{0, 0, 1, 32'h12, 1, 1, 0, 32'h0,  2};
      tbl[3] = '{0, 0, 1, 32'h13, 1, 1, 1, 32'h10, 3};
      tbl[4] = '{0, 0, 0, 32'h0,  1, 1, 1, 32'h11, 3};
      tbl[5] = '{0, 0, 0, 32'h0,  1, 1, 1, 32'h12, 2};
      tbl[6] = '{0, 0, 0, 32'h0,  1, 1, 1, 32'h13, 1};
      tbl[7] = '{0, 0, 0, 32'h0,  1, 1, 0, 32'h0,  0};

      rst = 1'b0;
      freeze = 0; flush = 0; in_valid = 0; out_ready = 0;
      in_data = '0; in_chan = '0;
      @(negedge clk);
      #1;
      chk("rst_occ3", 32'(occ3), 0);
      chk("rst_ov3", 32'(ov3), 0);
      chk("rst_ird3", 32'(ird3), 1);
      chk("rst_occ1", 32'(occ1), 0);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].fz, tbl[i].fl, tbl[i].iv, tbl[i].id,
              tbl[i].id[1:0], tbl[i].ordy);
         chk("tbl_in_ready", 32'(s_ird3), 32'(tbl[i].e_ird));
         chk("tbl_out_valid", 32'(s_ov3), 32'(tbl[i].e_ov));
         chk("tbl_occupancy", 32'(s_occ3), 32'(tbl[i].e_occ));
         if (tbl[i].e_ov) chk("tbl_out_data", s_od3, tbl[i].e_od);
      end

      // backpressure: five offers, only three fit
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 32'h10 + 32'(acc), 2'(acc), 0);
         if (s_ird3) acc++;
      end
      chk("fill_accepts", 32'(acc), 3);
      chk("fill_occ", 32'(occ3), 3);
      chk("fill_in_ready", 32'(ird3), 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 0, 1);
         if (i < 3) chk("drain_data", s_od3, 32'h10 + 32'(i));
      end

      // bubble collapse
      step(0, 0, 1, 32'hA0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 32'hA1, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("bubble_occ", 32'(s_occ3), 2);
      step(0, 0, 0, 0, 0, 1);
      chk("bubble_first", s_od3, 32'hA0);
      step(0, 0, 0, 0, 0, 1);
      chk("bubble_second_v", 32'(s_ov3), 1);
      chk("bubble_second", s_od3, 32'hA1);
      step(0, 0, 0, 0, 0, 1);

      // freeze mid-stream with rotating channels
      acc = 0;
      for (int c = 0; c < 16; c++) begin
         bit fz;
         fz = (c >= 5 && c < 9);
         step(fz, 0, acc < 10, 32'h20 + 32'(acc), 2'(acc), 1);
         if (fz) begin
            chk("frz_in_ready", 32'(s_ird3), 0);
            chk("frz_out_valid", 32'(s_ov3), 0);
         end else if (s_ird3 && acc < 10) begin
            acc++;
         end
      end

      // flush while frozen takes priority
      for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h30 + 32'(i), 2'(i), 0);
      chk("pre_flush_occ", 32'(occ3), 3);
      step(1, 1, 1, 32'h3F, 0, 1);
      chk("flush_ov", 32'(s_ov3), 0);
      chk("flush_ird", 32'(s_ird3), 0);
      step(0, 0, 1, 32'h55, 1, 1);
      chk("post_flush_occ", 32'(s_occ3), 0);
      lat = 0;
      hit = 0;
      for (int n = 1; n <= 10 && !hit; n++) begin
         step(0, 0, 0, 0, 0, 1);
         if (s_ov3) begin
            hit = 1;
            lat = n;
            chk("flush_word", s_od3, 32'h55);
         end
      end
      chk("flush_latency", 32'(lat), 3);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 3) != 0, $urandom, 2'($urandom),
              $urandom_range(0, 9) < 7);
      end

      // async reset between edges with two words held
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 32'h61, 1, 0);
      step(0, 0, 1, 32'h62, 2, 0);
      chk("pre_rst_occ", 32'(occ3), 2);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_occ3", 32'(occ3), 0);
      chk("arst_ov3", 32'(ov3), 0);
      chk("arst_occ1", 32'(occ1), 0);
      chk("arst_ov1", 32'(ov1), 0);
      q3 = {};
      q1 = {};
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      // DEPTH=1 streaming: latency 1, one word per cycle
      for (int i = 0; i < 6; i++) begin
         step(0, 0, i < 4, 32'h10 + 32'(i), 2'(i), 1);
         if (i >= 1 && i <= 4) begin
            chk("d1_stream_v", 32'(s_ov1), 1);
            chk("d1_stream_d", s_od1, 32'h10 + 32'(i - 1));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
